// File: rtl/fetch_pkg.sv
// Fetch stage shared types, constants and helpers.
package fetch_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // One fetch queue entry: the instruction together with the address it came from.
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        if (en && (val != 32'hFFFF_FFFF)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch queue with a single-cycle flush. Supports enqueue into a full queue
// when a dequeue happens in the same cycle; the caller guarantees deq only when not empty.
module fetch_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [63:0]
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    enq,
    input  entry_t                  enq_data,
    input  logic                    deq,
    output entry_t                  head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];

    // Pointer and occupancy next-state; flush wins over any enqueue/dequeue.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Storage write; a full queue overwrites the slot being read out this same cycle.
    always_comb begin
        mem_d = mem_q;
        if (enq && !flush) begin
            mem_d[wr_ptr_q] = enq_data;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: only slots below count are ever observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the PC, captures icache hits into a fetch queue and hands
// entries to decode over valid/ready. Redirects flush the queue and restart at the target.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_miss_cnt,
    output logic [31:0] perf_full_cnt,
    output logic [31:0] perf_redirect_cnt,
`endif
    output logic [31:0] ic_pc,
    input  logic [31:0] ic_inst,
    input  logic        ic_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    logic [31:0]            pc_q, pc_d;
    logic                   enq, deq;
    fetch_entry_t           enq_entry;
    fetch_entry_t           fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full, fifo_empty;

    // Handshake decode; redirect hides the head so no dequeue is reported that cycle.
    always_comb begin
        out_valid = !fifo_empty && !redirect;
        deq       = out_valid && out_ready;
        enq       = ic_valid && !redirect && (!fifo_full || deq);
        enq_entry = '{pc: pc_q, inst: ic_inst};
        out_pc    = fifo_empty ? '0 : fifo_head.pc;
        out_inst  = fifo_empty ? '0 : fifo_head.inst;
    end

    // PC next-state: redirect target (word aligned), else step on enqueue, else hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (enq) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ic_pc = pc_q;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .enq      (enq),
        .enq_data (enq_entry),
        .deq      (deq),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Occupancy is only needed as full/empty here; target low bits are dropped by alignment.
    logic unused_sig;
    assign unused_sig = ^{fifo_count, redirect_pc[1:0]};

`ifdef FETCH_PERF_EN
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] full_cnt_q, full_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    // Saturating event counters: icache misses, stalls on a full queue, redirects.
    always_comb begin
        miss_cnt_d  = sat_inc(miss_cnt_q, !ic_valid && !redirect);
        full_cnt_d  = sat_inc(full_cnt_q, fifo_full && !deq && ic_valid && !redirect);
        redir_cnt_d = sat_inc(redir_cnt_q, redirect);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q  <= '0;
            full_cnt_q  <= '0;
            redir_cnt_q <= '0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            full_cnt_q  <= full_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign perf_miss_cnt     = miss_cnt_q;
    assign perf_full_cnt     = full_cnt_q;
    assign perf_redirect_cnt = redir_cnt_q;
`endif

endmodule
